// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one slow line-granular memory port between the I-cache and D-cache
//   miss/write-back interfaces. One requester owns the port at a time, and it
//   keeps the port until the memory returns ready. The D side normally wins.
//   A 4-bit streak counter limits how many D grants can pass a pending I
//   request, so the I side always makes progress.
//
// Ports
//   clk, proc_reset          clock, synchronous active-high reset
//   i_mem_* / d_mem_*        cache-side request (read, write, addr, wdata) and
//                            return (rdata, ready)
//   mem_*                    memory-side request and return
//   grant_i, grant_d         registered ownership flags
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 28,
    parameter int unsigned LINE_W       = 128,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [LINE_W-1:0] i_mem_wdata,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              grant_i,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       req_i, req_d;

    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;

    // Grants are only issued from idle. A serving state always returns to idle
    // first, so every grant is preceded by at least one bubble cycle.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            StIdle: begin
                if (req_d && (!req_i || (streak_q < 4'(MAX_D_STREAK)))) begin
                    state_d = StServeD;
                    // Only D grants that pass a waiting I request count.
                    if (req_i) begin
                        streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (req_i) begin
                    state_d  = StServeI;
                    streak_d = 4'd0;
                end
            end
            StServeI, StServeD: begin
                if (mem_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q  <= StIdle;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Memory mux and return path, driven only by registered state.
    always_comb begin
        grant_i   = (state_q == StServeI);
        grant_d   = (state_q == StServeD);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_read  = d_mem_read;
            mem_write = d_mem_write;
            mem_addr  = d_mem_addr;
            mem_wdata = d_mem_wdata;
        end else if (grant_i) begin
            mem_read  = i_mem_read;
            mem_write = i_mem_write;
            mem_addr  = i_mem_addr;
            mem_wdata = i_mem_wdata;
        end
    end

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign i_mem_ready = mem_ready & grant_i;
    assign d_mem_ready = mem_ready & grant_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned MAX    = 4;

    logic              clk;
    logic              proc_reset;
    logic              i_mem_read, i_mem_write;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [LINE_W-1:0] i_mem_wdata, i_mem_rdata;
    logic              i_mem_ready;
    logic              d_mem_read, d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [LINE_W-1:0] d_mem_wdata, d_mem_rdata;
    logic              d_mem_ready;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic              mem_ready;
    logic              grant_i, grant_d;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .LINE_W       (LINE_W),
        .MAX_D_STREAK (MAX)
    ) dut (
        .clk         (clk),
        .proc_reset  (proc_reset),
        .i_mem_read  (i_mem_read),
        .i_mem_write (i_mem_write),
        .i_mem_addr  (i_mem_addr),
        .i_mem_wdata (i_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ready (i_mem_ready),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_rdata (d_mem_rdata),
        .d_mem_ready (d_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .grant_i     (grant_i),
        .grant_d     (grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the port (0 none, 1 I, 2 D) and how many D
    // grants have overtaken the currently waiting I request.
    int m_owner  = 0;
    int m_streak = 0;

    always @(posedge clk) begin
        if (proc_reset) begin
            m_owner  <= 0;
            m_streak <= 0;
        end else if (m_owner == 0) begin
            if ((d_mem_read || d_mem_write) &&
                (!(i_mem_read || i_mem_write) || m_streak < int'(MAX))) begin
                m_owner  <= 2;
                m_streak <= (i_mem_read || i_mem_write) ?
                            ((m_streak + 1 > 15) ? 15 : m_streak + 1) : 0;
            end else if (i_mem_read || i_mem_write) begin
                m_owner  <= 1;
                m_streak <= 0;
            end
        end else if (mem_ready) begin
            m_owner <= 0;
        end
    end

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        proc_reset = 1'b1;
        i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_addr = 28'h5; i_mem_wdata = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b1; d_mem_addr = 28'h6; d_mem_wdata = '1;
        mem_rdata = '0; mem_ready = 1'b1;
        step(); step();
        i_mem_read = 1'b0; d_mem_write = 1'b0; mem_ready = 1'b0;
        #1;
        checks++; if ({grant_i, grant_d} !== 2'b00) begin failures++;
            $display("FAIL reset_grants got=%b exp=00", {grant_i, grant_d}); end
        checks++; if ({mem_read, mem_write} !== 2'b00 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++; $display("FAIL reset_mem_port got=%b/%h exp=00/0",
                                 {mem_read, mem_write}, mem_addr); end
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b00) begin failures++;
            $display("FAIL reset_ready got=%b exp=00", {i_mem_ready, d_mem_ready}); end
        proc_reset = 1'b0;
    endtask

    task automatic test_lone_i_read();
        int               rdy;
        logic [LINE_W-1:0] data;
        rdy = 0;
        step(); i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
        step(); #1;
        checks++; if ({grant_i, grant_d, mem_read, mem_write} !== 4'b1010) begin failures++;
            $display("FAIL lone_grant got=%b exp=1010", {grant_i, grant_d, mem_read, mem_write}); end
        checks++; if (mem_addr !== 28'h0000010) begin failures++;
            $display("FAIL lone_addr got=%h exp=0000010", mem_addr); end
        repeat (4) begin
            step(); #1;
            if (i_mem_ready) rdy++;
            if (d_mem_ready) rdy += 100;
        end
        data = {$urandom, $urandom, $urandom, $urandom};
        step(); mem_ready = 1'b1; mem_rdata = data; #1;
        if (i_mem_ready) rdy++;
        if (d_mem_ready) rdy += 100;
        checks++; if (i_mem_rdata !== data) begin failures++;
            $display("FAIL lone_rdata got=%h exp=%h", i_mem_rdata, data); end
        step(); mem_ready = 1'b0; i_mem_read = 1'b0; #1;
        checks++; if (rdy !== 1) begin failures++;
            $display("FAIL lone_ready_count got=%0d exp=1", rdy); end
        checks++; if ({grant_i, grant_d, mem_read} !== 3'b000) begin failures++;
            $display("FAIL lone_back_idle got=%b exp=000", {grant_i, grant_d, mem_read}); end
    endtask

    task automatic test_d_priority();
        step();
        d_mem_write = 1'b1; d_mem_addr = 28'h0000020; d_mem_wdata = {16{8'hA5}};
        i_mem_read = 1'b1; i_mem_addr = 28'h0000031;
        step(); #1;
        checks++; if ({grant_i, grant_d, mem_read, mem_write} !== 4'b0101) begin failures++;
            $display("FAIL prio_d_first got=%b exp=0101", {grant_i, grant_d, mem_read, mem_write}); end
        checks++; if (mem_wdata !== {16{8'hA5}} || mem_addr !== 28'h0000020) begin failures++;
            $display("FAIL prio_d_fields got=%h/%h exp=a5../0000020", mem_wdata, mem_addr); end
        step(); mem_ready = 1'b1; #1;
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b01) begin failures++;
            $display("FAIL prio_d_ready got=%b exp=01", {i_mem_ready, d_mem_ready}); end
        step(); mem_ready = 1'b0; d_mem_write = 1'b0; #1;
        checks++; if ({grant_i, grant_d} !== 2'b00) begin failures++;
            $display("FAIL prio_bubble got=%b exp=00", {grant_i, grant_d}); end
        step(); #1;
        checks++; if ({grant_i, grant_d, mem_read} !== 3'b101 || mem_addr !== 28'h0000031) begin
            failures++; $display("FAIL prio_i_next got=%b/%h exp=101/0000031",
                                 {grant_i, grant_d, mem_read}, mem_addr); end
        step(); mem_ready = 1'b1;
        step(); mem_ready = 1'b0; i_mem_read = 1'b0;
    endtask

    task automatic test_starvation();
        int d_grants;
        d_grants = 0;
        step();
        i_mem_read = 1'b1; i_mem_addr = 28'h0000100;
        d_mem_read = 1'b1; d_mem_addr = 28'h0000200;
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            if (!grant_d) break;
            d_grants++;
            step(); mem_ready = 1'b1;
            step(); mem_ready = 1'b0; d_mem_addr = d_mem_addr + 28'h1;
        end
        checks++; if (d_grants !== int'(MAX)) begin failures++;
            $display("FAIL starve_d_count got=%0d exp=%0d", d_grants, MAX); end
        checks++; if ({grant_i, grant_d} !== 2'b10) begin failures++;
            $display("FAIL starve_i_granted got=%b exp=10", {grant_i, grant_d}); end
        step(); mem_ready = 1'b1;
        step(); mem_ready = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0;
        // Streak must be back at zero: a fresh tie goes to D again.
        step(); i_mem_read = 1'b1; d_mem_read = 1'b1;
        step(); #1;
        checks++; if ({grant_i, grant_d} !== 2'b01) begin failures++;
            $display("FAIL starve_streak_cleared got=%b exp=01", {grant_i, grant_d}); end
        step(); mem_ready = 1'b1;
        step(); mem_ready = 1'b0; d_mem_read = 1'b0;
        step(); #1;
        step(); mem_ready = 1'b1;
        step(); mem_ready = 1'b0; i_mem_read = 1'b0;
    endtask

    task automatic test_idle_ready();
        step(); mem_ready = 1'b1; #1;
        checks++; if ({i_mem_ready, d_mem_ready, grant_i, grant_d} !== 4'b0000) begin failures++;
            $display("FAIL idle_ready_fwd got=%b exp=0000",
                     {i_mem_ready, d_mem_ready, grant_i, grant_d}); end
        step(); mem_ready = 1'b0; #1;
        checks++; if ({grant_i, grant_d} !== 2'b00) begin failures++;
            $display("FAIL idle_ready_state got=%b exp=00", {grant_i, grant_d}); end
    endtask

    task automatic test_reset_mid();
        step(); d_mem_read = 1'b1; d_mem_addr = 28'h0000050;
        step(); #1;
        checks++; if (grant_d !== 1'b1) begin failures++;
            $display("FAIL rst_mid_pre got=%b exp=1", grant_d); end
        step(); proc_reset = 1'b1;
        step(); proc_reset = 1'b0; d_mem_read = 1'b0; #1;
        checks++; if ({grant_d, mem_read, mem_write} !== 3'b000 || mem_addr !== '0) begin
            failures++; $display("FAIL rst_mid_cleared got=%b/%h exp=000/0",
                                 {grant_d, mem_read, mem_write}, mem_addr); end
        step(); mem_ready = 1'b1; #1;
        checks++; if ({i_mem_ready, d_mem_ready} !== 2'b00) begin failures++;
            $display("FAIL rst_mid_stale got=%b exp=00", {i_mem_ready, d_mem_ready}); end
        step(); mem_ready = 1'b0; i_mem_read = 1'b1; i_mem_addr = 28'h0000060;
        step(); #1;
        checks++; if (grant_i !== 1'b1 || mem_addr !== 28'h0000060) begin failures++;
            $display("FAIL rst_mid_i_served got=%b/%h exp=1/0000060", grant_i, mem_addr); end
        step(); mem_ready = 1'b1; #1;
        checks++; if (i_mem_ready !== 1'b1) begin failures++;
            $display("FAIL rst_mid_i_ready got=%b exp=1", i_mem_ready); end
        step(); mem_ready = 1'b0; i_mem_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] r1, r2;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        step(); d_mem_read = 1'b1; d_mem_addr = 28'h0000030;
        step(); #1;
        checks++; if (grant_d !== 1'b1 || mem_addr !== 28'h0000030) begin failures++;
            $display("FAIL b2b_first got=%b/%h exp=1/0000030", grant_d, mem_addr); end
        step(); mem_ready = 1'b1; mem_rdata = r1; #1;
        checks++; if (d_mem_ready !== 1'b1 || d_mem_rdata !== r1) begin failures++;
            $display("FAIL b2b_first_ret got=%b/%h exp=1/%h", d_mem_ready, d_mem_rdata, r1); end
        step(); mem_ready = 1'b0; d_mem_addr = 28'h0000040; #1;
        checks++; if (grant_d !== 1'b0) begin failures++;
            $display("FAIL b2b_bubble got=%b exp=0", grant_d); end
        step(); #1;
        checks++; if (grant_d !== 1'b1 || mem_addr !== 28'h0000040) begin failures++;
            $display("FAIL b2b_second got=%b/%h exp=1/0000040", grant_d, mem_addr); end
        step(); mem_ready = 1'b1; mem_rdata = r2; #1;
        checks++; if (d_mem_ready !== 1'b1 || d_mem_rdata !== r2) begin failures++;
            $display("FAIL b2b_second_ret got=%b/%h exp=1/%h", d_mem_ready, d_mem_rdata, r2); end
        step(); mem_ready = 1'b0; d_mem_read = 1'b0;
    endtask

    task automatic test_random();
        logic i_busy, d_busy, i_seen, d_seen, rst_prev, issue;
        logic [1:0] kind;
        logic [1:0] exp_g, exp_rdy;
        logic exp_rd, exp_wr;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wd;
        i_busy = 0; d_busy = 0; i_seen = 0; d_seen = 0; rst_prev = 0;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (rst_prev) begin
                i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
                i_busy = 0; d_busy = 0; i_seen = 0; d_seen = 0;
            end
            issue = i_seen ? ($urandom_range(0, 1) == 0) : (!i_busy && $urandom_range(0, 3) == 0);
            if (i_seen) begin i_mem_read = 0; i_mem_write = 0; i_busy = 0; end
            if (issue) begin
                kind = 2'($urandom_range(0, 3));
                i_mem_read = (kind != 2'd2); i_mem_write = (kind >= 2'd2);
                i_mem_addr = ADDR_W'($urandom);
                i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
                i_busy = 1;
            end
            issue = d_seen ? ($urandom_range(0, 1) == 0) : (!d_busy && $urandom_range(0, 2) == 0);
            if (d_seen) begin d_mem_read = 0; d_mem_write = 0; d_busy = 0; end
            if (issue) begin
                kind = 2'($urandom_range(0, 3));
                d_mem_read = (kind != 2'd2); d_mem_write = (kind >= 2'd2);
                d_mem_addr = ADDR_W'($urandom);
                d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
                d_busy = 1;
            end
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            proc_reset = ($urandom_range(0, 149) == 0);
            rst_prev = proc_reset;
            #1;
            exp_g = {m_owner == 1, m_owner == 2};
            exp_rdy = exp_g & {2{mem_ready}};
            exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wd = '0;
            if (m_owner == 1) begin
                exp_rd = i_mem_read; exp_wr = i_mem_write; exp_addr = i_mem_addr; exp_wd = i_mem_wdata;
            end else if (m_owner == 2) begin
                exp_rd = d_mem_read; exp_wr = d_mem_write; exp_addr = d_mem_addr; exp_wd = d_mem_wdata;
            end
            checks++; if ({grant_i, grant_d} !== exp_g) begin failures++;
                $display("FAIL rand_grant n=%0d got=%b exp=%b", n, {grant_i, grant_d}, exp_g); end
            checks++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== {exp_rd, exp_wr, exp_addr, exp_wd})
            begin failures++;
                $display("FAIL rand_mem_port n=%0d got=%b%b/%h exp=%b%b/%h", n, mem_read, mem_write,
                         mem_addr, exp_rd, exp_wr, exp_addr); end
            checks++; if ({i_mem_ready, d_mem_ready} !== exp_rdy) begin failures++;
                $display("FAIL rand_ready n=%0d got=%b exp=%b", n, {i_mem_ready, d_mem_ready}, exp_rdy); end
            checks++; if (i_mem_rdata !== mem_rdata || d_mem_rdata !== mem_rdata) begin failures++;
                $display("FAIL rand_rdata n=%0d got=%h/%h exp=%h", n, i_mem_rdata, d_mem_rdata,
                         mem_rdata); end
            i_seen = exp_rdy[1];
            d_seen = exp_rdy[0];
        end
        step();
        proc_reset = 0; mem_ready = 0;
        i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
    endtask

    initial begin
        test_reset();
        test_lone_i_read();
        test_d_priority();
        test_starvation();
        test_idle_ready();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow-memory port between the instruction-cache and data-cache miss/write-back interfaces. This lets a single off-chip memory serve both caches.
- Sits between the two cache instances and the memory.
- Grants one requester at a time and holds the grant until the memory returns ready.
- D-side has priority; a starvation counter guarantees I-side forward progress.

Parameters:
- ADDR_W, 28, line-address width (byte address bits 31:4)
- LINE_W, 128, cache-line data width
- MAX_D_STREAK, 4, maximum consecutive D grants while an I request is pending; 1..15

Ports:
- clk  in  1  clock
- proc_reset  in  1  synchronous active-high reset
- i_mem_read  in  1  I-cache line read request
- i_mem_write  in  1  I-cache line write request
- i_mem_addr  in  ADDR_W  I-cache line address
- i_mem_wdata  in  LINE_W  I-cache write line
- i_mem_rdata  out  LINE_W  read line to I-cache
- i_mem_ready  out  1  completion to I-cache
- d_mem_read  in  1  D-cache line read request
- d_mem_write  in  1  D-cache write-back request
- d_mem_addr  in  ADDR_W  D-cache line address
- d_mem_wdata  in  LINE_W  D-cache write line
- d_mem_rdata  out  LINE_W  read line to D-cache
- d_mem_ready  out  1  completion to D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line
- mem_ready  in  1  memory completion (one-cycle pulse)
- grant_i  out  1  registered: I owns the port
- grant_d  out  1  registered: D owns the port

Behaviour:
- Request definitions: req_i = i_mem_read | i_mem_write; req_d = d_mem_read | d_mem_write.
- Requester contract: a requester holds read, write, addr and wdata stable from assertion until its ready pulse, and deasserts them the cycle after.
- FSM states: IDLE, SERVE_I, SERVE_D. Encoding is free. grant_i = (state==SERVE_I); grant_d = (state==SERVE_D).
- IDLE:
  - req_d & (~req_i | streak<MAX_D_STREAK) -> SERVE_D.
  - else req_i -> SERVE_I.
  - else stay in IDLE.
- SERVE_x:
  - mem_ready=1 -> IDLE.
  - else stay.
  - IDLE always lasts at least one cycle between grants (bubble). This prevents re-serving a request that is deasserted late.
- Memory port mux (combinational from registered state):
  - SERVE_D drives the d_* request fields to mem_*.
  - SERVE_I drives the i_* request fields.
  - IDLE drives mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Latency: a request first seen in IDLE at cycle t appears on mem_read/mem_write at t+1.
- Return path:
  - i_mem_rdata and d_mem_rdata both equal mem_rdata at all times (broadcast).
  - i_mem_ready = mem_ready & grant_i; d_mem_ready = mem_ready & grant_d.
- mem_ready while in IDLE: ignored, no state change, no ready forwarded.
- Read and write asserted together by one requester: both are passed through unchanged. Legality is the cache's responsibility.
- Streak counter, 4 bits:
  - On entering SERVE_D with req_i=1: streak += 1, saturating at 15.
  - On entering SERVE_I: streak = 0.
  - On entering SERVE_D with req_i=0: streak = 0.
- Simultaneous req_i and req_d in IDLE with streak<MAX_D_STREAK: D wins.
- Simultaneous req_i and req_d in IDLE with streak>=MAX_D_STREAK: I wins.
- A requester that drops its request before ready is a contract violation. The FSM still waits for mem_ready, with no timeout.
- Reset, including mid-transaction, forces the following on the next edge:
  - state=IDLE and streak=0.
  - grant_i=0 and grant_d=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - i_mem_ready=0 and d_mem_ready=0.
  - Any outstanding memory transaction is abandoned. A later mem_ready arrives in IDLE and is ignored.

Test Plan:
- Lone I read (i_mem_read=1, addr=0x0000010) with memory ready after 5 cycles -> grant_i=1 and mem_read=1 with mem_addr=0x0000010 one cycle after the request; i_mem_ready pulses exactly once; d_mem_ready stays 0; back in IDLE with grant_i=0 the cycle after ready.
- Simultaneous D write-back (addr=0x0000020, wdata=0xA5..A5) and I read -> D served first (mem_write=1, mem_wdata=0xA5..A5); after D's ready, one IDLE cycle, then I granted.
- I held pending with D re-requesting immediately each time and MAX_D_STREAK=4 -> exactly 4 D grants, then the I grant; streak returns to 0.
- mem_ready pulse injected while IDLE with no requests -> no ready on either side, no state change.
- proc_reset asserted for 1 cycle during SERVE_D -> next cycle grant_d=0 and mem_read=mem_write=0; a subsequent stale mem_ready is ignored; a new I request is then served normally.
- Back-to-back D reads to 0x0000030 then 0x0000040 -> two separate grants separated by one IDLE cycle; d_mem_rdata matches mem_rdata on each ready pulse.
